// File: rtl/mph_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mph_pkg : shared encodings, register map and helpers for project_sequencer  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mph_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MUTE    = 2'd1,
        ST_SWAP    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_SELECT = 8'h04;
    localparam logic [7:0] OFF_DWELL  = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;

    localparam int STAT_ACT_LSB   = 0;
    localparam int STAT_STATE_LSB = 8;
    localparam int STAT_ERR_BIT   = 10;
    localparam int STAT_CNT_LSB   = 16;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [7:0] next_project(input logic [7:0] cur,
                                                input logic [7:0] num);
        return (cur >= num - 8'd1) ? 8'd0 : cur + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dwell_timer : counts enabled cycles, pulses expire on the limit-th cycle   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dwell_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] limit,
    output logic        expire
);

    logic [31:0] count_q, count_d;
    logic        armed;

    // A zero limit disables the timer entirely and pins the count at 0.
    assign armed  = enable & (limit != 32'd0);
    assign expire = armed & (count_q == limit - 32'd1);

    always_comb begin
        count_d = count_q + 32'd1;
        if (load || !armed || expire) count_d = 32'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count_q <= 32'd0;
        else          count_q <= count_d;
    end

endmodule
`default_nettype wire

// File: rtl/project_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | project_sequencer : wishbone-controlled project switcher with mute/reset   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module project_sequencer
    import mph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h30000500,
    parameter int unsigned NUM_PROJECTS = 5,
    parameter int unsigned RESET_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  active_project,
    output logic        project_reset,
    output logic        io_mute
);

    localparam logic [8:0] NUM_P9  = NUM_PROJECTS[8:0];
    localparam logic [7:0] NUM_P8  = NUM_PROJECTS[7:0];
    localparam logic [7:0] RC_LAST = 8'(RESET_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  active_q, active_d;
    logic [7:0]  tgt_q, tgt_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_tgt_q, pend_tgt_d;
    logic [7:0]  cyc_q, cyc_d;
    logic [15:0] swcnt_q, swcnt_d;
    logic        auto_en_q, auto_en_d;
    logic [7:0]  select_q, select_d;
    logic [31:0] dwell_q, dwell_d;
    logic        sel_err_q, sel_err_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        rst_hold_q;

    logic        bus_valid, in_window, accept, is_write;
    logic [7:0]  reg_off;
    logic        wr_ctrl, wr_select, wr_dwell, wr_status;
    logic        sel_byte0, sel_valid, sel_bad;
    logic        fsm_load, dwell_expire;
    logic [31:0] status, rd_data;
    logic        unused_adr_bits;

    assign unused_adr_bits = ^wbs_adr_i[1:0];

    // The ack_q term enforces a dead cycle after every ack.
    assign bus_valid = wbs_cyc_i & wbs_stb_i;
    assign in_window = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign accept    = bus_valid & in_window & ~ack_q;
    assign is_write  = wbs_we_i & (|wbs_sel_i);
    assign reg_off   = {wbs_adr_i[7:2], 2'b00};

    assign wr_ctrl   = accept & is_write & (reg_off == OFF_CTRL);
    assign wr_select = accept & is_write & (reg_off == OFF_SELECT);
    assign wr_dwell  = accept & is_write & (reg_off == OFF_DWELL);
    assign wr_status = accept & is_write & (reg_off == OFF_STATUS);
    assign sel_byte0 = wr_select & wbs_sel_i[0];
    assign sel_valid = sel_byte0 & ({1'b0, wbs_dat_i[7:0]} < NUM_P9);
    assign sel_bad   = sel_byte0 & ~sel_valid;

    always_comb begin
        status = 32'd0;
        status[STAT_ACT_LSB +: 8]   = active_q;
        status[STAT_STATE_LSB +: 2] = state_q;
        status[STAT_ERR_BIT]        = sel_err_q;
        status[STAT_CNT_LSB +: 16]  = swcnt_q;
    end

    always_comb begin
        rd_data = 32'd0;
        case (reg_off)
            OFF_CTRL:   rd_data = {31'd0, auto_en_q};
            OFF_SELECT: rd_data = {24'd0, select_q};
            OFF_DWELL:  rd_data = dwell_q;
            OFF_STATUS: rd_data = status;
            default:    rd_data = 32'd0;
        endcase
    end

    always_comb begin
        auto_en_d = auto_en_q;
        select_d  = select_q;
        dwell_d   = dwell_q;
        sel_err_d = sel_err_q;
        if (wr_ctrl && wbs_sel_i[0]) auto_en_d = wbs_dat_i[0];
        if (sel_valid)               select_d  = wbs_dat_i[7:0];
        if (wr_dwell)                dwell_d   = merge_bytes(dwell_q, wbs_dat_i, wbs_sel_i);
        if (wr_status)               sel_err_d = 1'b0;
        if (sel_bad)                 sel_err_d = 1'b1;
        ack_d = accept;
        dat_d = (accept && !is_write) ? rd_data : 32'd0;
    end

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        tgt_d      = tgt_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        cyc_d      = cyc_q;
        swcnt_d    = swcnt_q;
        fsm_load   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pend_q) begin
                    tgt_d    = pend_tgt_q;
                    pend_d   = 1'b0;
                    state_d  = ST_MUTE;
                    fsm_load = 1'b1;
                end else if (dwell_expire) begin
                    tgt_d    = next_project(active_q, NUM_P8);
                    state_d  = ST_MUTE;
                    fsm_load = 1'b1;
                end
            end
            ST_MUTE: begin
                active_d = tgt_q;
                cyc_d    = 8'd0;
                state_d  = ST_SWAP;
            end
            ST_SWAP: begin
                if (cyc_q == RC_LAST) state_d = ST_RELEASE;
                else                  cyc_d   = cyc_q + 8'd1;
            end
            ST_RELEASE: begin
                if (swcnt_q != 16'hFFFF) swcnt_d = swcnt_q + 16'd1;
                fsm_load = 1'b1;
                state_d  = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        // A new request recorded this cycle overrides any consumption above.
        if (sel_valid) begin
            pend_d     = 1'b1;
            pend_tgt_d = wbs_dat_i[7:0];
        end
    end

    dwell_timer u_dwell_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (auto_en_q & (state_q == ST_RUN)),
        .load    (fsm_load | wr_dwell),
        .limit   (dwell_q),
        .expire  (dwell_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            active_q   <= 8'd0;
            tgt_q      <= 8'd0;
            pend_q     <= 1'b0;
            pend_tgt_q <= 8'd0;
            cyc_q      <= 8'd0;
            swcnt_q    <= 16'd0;
            auto_en_q  <= 1'b0;
            select_q   <= 8'd0;
            dwell_q    <= 32'd0;
            sel_err_q  <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            tgt_q      <= tgt_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            cyc_q      <= cyc_d;
            swcnt_q    <= swcnt_d;
            auto_en_q  <= auto_en_d;
            select_q   <= select_d;
            dwell_q    <= dwell_d;
            sel_err_q  <= sel_err_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            rst_hold_q <= 1'b0;
        end
    end

    // rst_hold_q keeps the project in reset and muted until the first edge after reset.
    assign active_project = active_q;
    assign project_reset  = rst_hold_q | (state_q == ST_SWAP);
    assign io_mute        = rst_hold_q | (state_q != ST_RUN);
    assign wbs_ack_o      = ack_q;
    assign wbs_dat_o      = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_project_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_project_sequencer : directed self-checking bench for project_sequencer  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_project_sequencer;

    localparam logic [31:0] BASE = 32'h30000500;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [7:0]  active_project;
    logic        project_reset, io_mute;

    int n_checks = 0;
    int n_pass   = 0;

    project_sequencer #(
        .BASE_ADDR    (BASE),
        .NUM_PROJECTS (5),
        .RESET_CYCLES (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wbs_stb_i      (wbs_stb_i),
        .wbs_cyc_i      (wbs_cyc_i),
        .wbs_we_i       (wbs_we_i),
        .wbs_sel_i      (wbs_sel_i),
        .wbs_adr_i      (wbs_adr_i),
        .wbs_dat_i      (wbs_dat_i),
        .wbs_ack_o      (wbs_ack_o),
        .wbs_dat_o      (wbs_dat_o),
        .active_project (active_project),
        .project_reset  (project_reset),
        .io_mute        (io_mute)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic ack, output logic [31:0] rd);
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        @(posedge clk); #1;
        ack = wbs_ack_o;
        rd  = wbs_dat_o;
        @(negedge clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    endtask

    task automatic wb_wr(input string tag, input logic [7:0] off, input logic [31:0] dat,
                         input logic [3:0] sel);
        logic ack;
        logic [31:0] rd;
        wb_xfer(BASE + {24'd0, off}, 1'b1, dat, sel, ack, rd);
        check_eq({tag, "_ack"}, {31'd0, ack}, 32'd1);
    endtask

    task automatic wb_rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic ack;
        logic [31:0] rd;
        wb_xfer(BASE + {24'd0, off}, 1'b0, 32'd0, 4'hF, ack, rd);
        check_eq({tag, "_ack"}, {31'd0, ack}, 32'd1);
        check_eq(tag, rd, exp);
    endtask

    // Samples at each falling edge until a mute window opens and closes.
    task automatic wait_switch(output int mute_n, output int prst_n,
                               output logic [7:0] act_swap, output int start_k);
        bit seen_mute = 0, seen_rst = 0, done = 0;
        mute_n = 0; prst_n = 0; act_swap = 8'hFF; start_k = -1;
        for (int k = 1; k <= 400 && !done; k++) begin
            @(negedge clk);
            if (io_mute) begin
                mute_n++;
                if (!seen_mute) start_k = k;
                seen_mute = 1;
            end else if (seen_mute) begin
                done = 1;
            end
            if (project_reset) begin
                prst_n++;
                if (!seen_rst) act_swap = active_project;
                seen_rst = 1;
            end
        end
        check_eq("switch_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int mute_n, prst_n, start_k;
        logic [7:0] act_swap;
        logic ack, ack_any;
        logic [31:0] rd;

        // Reset values while reset_n is low
        repeat (3) @(negedge clk);
        check_eq("rst_active", {24'd0, active_project}, 32'd0);
        check_eq("rst_prst", {31'd0, project_reset}, 32'd1);
        check_eq("rst_mute", {31'd0, io_mute}, 32'd1);
        check_eq("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check_eq("rst_dat", wbs_dat_o, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_prst", {31'd0, project_reset}, 32'd0);
        check_eq("post_rst_mute", {31'd0, io_mute}, 32'd0);
        wb_rd_chk("status_reset", 8'h0C, 32'd0);

        // Byte-enable merge on DWELL
        wb_wr("dwell_full", 8'h08, 32'h11223344, 4'hF);
        wb_wr("dwell_byte2", 8'h08, 32'hAABBCCDD, 4'b0100);
        wb_rd_chk("dwell_merge", 8'h08, 32'h11BB3344);
        wb_wr("dwell_zero", 8'h08, 32'h0, 4'hF);

        // Manual switch to 3
        wb_wr("sel3", 8'h04, 32'd3, 4'hF);
        wait_switch(mute_n, prst_n, act_swap, start_k);
        check_eq("sel3_mute_cycles", mute_n, 32'd18);
        check_eq("sel3_prst_cycles", prst_n, 32'd16);
        check_eq("sel3_active_at_swap", {24'd0, act_swap}, 32'd3);
        wb_rd_chk("status_after_sel3", 8'h0C, 32'h0001_0003);

        // Out-of-range select
        wb_wr("sel7", 8'h04, 32'd7, 4'hF);
        repeat (3) @(negedge clk);
        check_eq("sel7_active", {24'd0, active_project}, 32'd3);
        check_eq("sel7_mute", {31'd0, io_mute}, 32'd0);
        wb_rd_chk("status_err_set", 8'h0C, 32'h0001_0403);
        wb_rd_chk("select_kept", 8'h04, 32'd3);
        wb_wr("status_clr", 8'h0C, 32'd0, 4'hF);
        wb_rd_chk("status_err_clr", 8'h0C, 32'h0001_0003);

        // SELECT without byte 0 enabled is ignored
        wb_wr("sel_nobyte0", 8'h04, 32'h0000_0101, 4'b0010);
        repeat (3) @(negedge clk);
        check_eq("nobyte0_mute", {31'd0, io_mute}, 32'd0);
        wb_rd_chk("status_nobyte0", 8'h0C, 32'h0001_0003);

        // Held access: ack, gap, ack; data only in ack cycles
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = BASE + 32'h4; wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        check_eq("hold_ack0", {31'd0, wbs_ack_o}, 32'd1);
        check_eq("hold_dat0", wbs_dat_o, 32'd3);
        @(posedge clk); #1;
        check_eq("hold_ack1", {31'd0, wbs_ack_o}, 32'd0);
        check_eq("hold_dat1", wbs_dat_o, 32'd0);
        @(posedge clk); #1;
        check_eq("hold_ack2", {31'd0, wbs_ack_o}, 32'd1);
        @(negedge clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;

        // Unmapped offset in window, and outside window
        wb_rd_chk("unmapped_0x40", 8'h40, 32'd0);
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = BASE + 32'h100; wbs_sel_i = 4'hF;
        ack_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            ack_any = ack_any | wbs_ack_o;
        end
        @(negedge clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check_eq("outside_no_ack", {31'd0, ack_any}, 32'd0);

        // Request queued during SWAP
        wb_wr("sel1", 8'h04, 32'd1, 4'hF);
        ack_any = 1'b0;
        for (int i = 0; i < 50 && !ack_any; i++) begin
            @(negedge clk);
            ack_any = project_reset;
        end
        check_eq("sel1_swap_seen", {31'd0, ack_any}, 32'd1);
        wb_wr("sel2_in_swap", 8'h04, 32'd2, 4'hF);
        wait_switch(mute_n, prst_n, act_swap, start_k);
        check_eq("first_switch_active", {24'd0, active_project}, 32'd1);
        wait_switch(mute_n, prst_n, act_swap, start_k);
        check_eq("second_mute_cycles", mute_n, 32'd18);
        check_eq("second_active_at_swap", {24'd0, act_swap}, 32'd2);
        repeat (5) @(negedge clk);
        check_eq("no_third_switch", {31'd0, io_mute}, 32'd0);
        wb_rd_chk("status_after_queue", 8'h0C, 32'h0003_0002);

        // Automatic dwell switch with wrap 4 -> 0
        wb_wr("sel4", 8'h04, 32'd4, 4'hF);
        wait_switch(mute_n, prst_n, act_swap, start_k);
        check_eq("sel4_active", {24'd0, act_swap}, 32'd4);
        wb_wr("ctrl_on", 8'h00, 32'd1, 4'hF);
        wb_wr("dwell100", 8'h08, 32'd100, 4'hF);
        wait_switch(mute_n, prst_n, act_swap, start_k);
        check_eq("auto_run_cycles", start_k, 32'd100);
        check_eq("auto_wrap_active", {24'd0, act_swap}, 32'd0);
        check_eq("auto_prst_cycles", prst_n, 32'd16);
        wb_rd_chk("status_after_auto", 8'h0C, 32'h0005_0000);
        wb_wr("ctrl_off", 8'h00, 32'd0, 4'hF);

        // Reset asserted mid-SWAP with a pending request
        wb_wr("sel2_pre_rst", 8'h04, 32'd2, 4'hF);
        ack_any = 1'b0;
        for (int i = 0; i < 50 && !ack_any; i++) begin
            @(negedge clk);
            ack_any = project_reset;
        end
        check_eq("pre_rst_swap_seen", {31'd0, ack_any}, 32'd1);
        wb_wr("sel1_pending", 8'h04, 32'd1, 4'hF);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_active", {24'd0, active_project}, 32'd0);
        check_eq("midrst_prst", {31'd0, project_reset}, 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("after_rst_mute", {31'd0, io_mute}, 32'd0);
        check_eq("after_rst_active", {24'd0, active_project}, 32'd0);
        wb_rd_chk("status_after_rst", 8'h0C, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/project_sequencer.md
PROJECT_SEQUENCER -- requirements
Module: project_sequencer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h30000500, meaning the base address of its 0x100-byte wishbone window.
REQ-002 The block SHALL have parameter NUM_PROJECTS, default 5, meaning the number of selectable projects (1..255).
REQ-003 The block SHALL have parameter RESET_CYCLES, default 16, meaning how long project_reset is held per switch (1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports wbs_stb_i, wbs_cyc_i and wbs_we_i, inputs, 1 bit each: wishbone strobe, cycle and write enable.
REQ-007 The block SHALL have ports wbs_sel_i (input, 4 bits), wbs_adr_i (input, 32 bits) and wbs_dat_i (input, 32 bits): byte select, address and write data.
REQ-008 The block SHALL have ports wbs_ack_o (output, 1 bit) and wbs_dat_o (output, 32 bits): acknowledge and read data.
REQ-009 The block SHALL have port active_project, output, 8 bits: the project currently driving the IO mux.
REQ-010 The block SHALL have port project_reset, output, 1 bit: active-high reset to the newly selected project.
REQ-011 The block SHALL have port io_mute, output, 1 bit: when high, the harness forces io_out to 0.

Function
REQ-012 A wishbone access SHALL be valid when wbs_cyc_i and wbs_stb_i are both high; it is a write if wbs_we_i is high and wbs_sel_i is non-zero, otherwise a read.
REQ-013 Registers SHALL be: +0x0 CTRL (bit0 auto_en), +0x4 SELECT (bits 7:0), +0x8 DWELL (32-bit cycle count), +0xC STATUS (read-only: [7:0] active_project, [9:8] state, [10] sel_err, [31:16] switch_count).
REQ-014 Writes SHALL update only the bytes enabled by wbs_sel_i; a SELECT write takes effect only if byte 0 is enabled.
REQ-015 A valid access inside the window SHALL produce wbs_ack_o high for exactly one cycle, the cycle after the access is sampled.
REQ-016 After an ack, wbs_ack_o SHALL be low for at least one cycle, even if the access is still held valid.
REQ-017 Read data SHALL be presented in the ack cycle; wbs_dat_o SHALL be 0 in all other cycles and for unmapped offsets.
REQ-018 Accesses outside the window SHALL never be acked.
REQ-019 The FSM SHALL have states RUN=0, MUTE=1, SWAP=2 and RELEASE=3.
REQ-020 In RUN, a pending switch SHALL cause a move to MUTE.
REQ-021 MUTE SHALL last 1 cycle with io_mute=1, then move to SWAP.
REQ-022 On entry to SWAP, active_project SHALL load the target; in SWAP, project_reset=1 and io_mute=1 for RESET_CYCLES cycles, then the FSM moves to RELEASE.
REQ-023 RELEASE SHALL last 1 cycle with io_mute=1 and project_reset=0, increment switch_count (saturating at 16'hFFFF), reload the dwell counter, and return to RUN.
REQ-024 A SELECT write with value < NUM_PROJECTS SHALL set a pending manual switch to that value.
REQ-025 A SELECT write with value >= NUM_PROJECTS SHALL be acked but otherwise ignored, and SHALL set sel_err; sel_err is cleared by a write to STATUS.
REQ-026 A SELECT write equal to active_project SHALL still perform the full switch sequence, i.e. re-reset that project.
REQ-027 When auto_en=1 and DWELL>0, the dwell counter SHALL count RUN cycles; reaching DWELL SHALL set a pending auto switch to active_project+1, wrapping from NUM_PROJECTS-1 to 0.
REQ-028 When DWELL=0 or auto_en=0, no auto switch SHALL occur and the counter SHALL hold at 0.
REQ-029 If a manual request and dwell expiry occur in the same cycle, the manual request SHALL win and the counter SHALL reload.
REQ-030 A SELECT write during MUTE, SWAP or RELEASE SHALL be stored as pending (last write wins) and serviced on the next RUN cycle.
REQ-031 Writing DWELL SHALL reload the dwell counter to 0.

Reset
REQ-032 While reset_n=0, the block SHALL hold all outputs at: active_project=0, project_reset=1, io_mute=1, wbs_ack_o=0, wbs_dat_o=0.
REQ-033 While reset_n=0, all registers SHALL be 0 and the FSM SHALL be in RUN.
REQ-034 Reset asserted mid-switch SHALL abort the switch and discard any pending request.
REQ-035 After reset_n rises, project_reset and io_mute SHALL fall on the first clk edge.

Structure
REQ-036 State encodings, register offsets and STATUS field positions SHALL live in a shared package, mph_pkg.
REQ-037 The dwell counter SHALL be a sub-module, dwell_timer (enable, load, limit, expire).

Verification
REQ-038 Bench SHALL cover: write SELECT=3 in RUN -> ack next cycle; io_mute high 1+16+1 cycles; active_project=3 from SWAP entry; project_reset high exactly 16 cycles; switch_count=1.
REQ-039 Bench SHALL cover: CTRL=1, DWELL=100, active_project=4 -> after 100 RUN cycles, switch to 0 (wrap).
REQ-040 Bench SHALL cover: SELECT=7 -> acked, active_project unchanged, STATUS[10]=1; STATUS write -> STATUS[10]=0.
REQ-041 Bench SHALL cover: SELECT=1 then SELECT=2 during SWAP -> after the first switch completes, one further switch to 2.
REQ-042 Bench SHALL cover: reset_n low during SWAP -> active_project=0 and RUN immediately; pending request dropped.
REQ-043 Bench SHALL cover: read at BASE_ADDR+0x40 -> ack with data 0; read at BASE_ADDR+0x100 -> no ack.
